// File: rtl/bn128_pkg.sv
// BN128 field element, Jacobian point and the packed {point, scalar} load word.
package bn128_pkg;

    typedef logic [255:0] fe_t;

    typedef struct packed {
        fe_t x;
        fe_t y;
        fe_t z;
    } jb_point_t;

    typedef struct packed {
        jb_point_t pnt;
        fe_t       scl;
    } pnt_scl_t;

    localparam int unsigned DAT_BITS = $bits(pnt_scl_t);

endpackage

// File: rtl/common_pkg.sv
// Generic stream sideband widths shared by every streaming block.
package common_pkg;

    localparam int unsigned STREAM_CTL_BITS = 8;
    localparam int unsigned STREAM_MOD_BITS = 8;

endpackage

// File: rtl/multiexp_feeder_pkg.sv
// Feeder FSM states and the pass-tag width carried beside each replayed word.
// The tag reaches ctl only when MULTIEXP_FEEDER_PASS_CTL_EN is defined.
package multiexp_feeder_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StReplay
    } state_e;

    localparam int unsigned TAG_BITS = 8;

endpackage

// File: rtl/if_axi_stream.sv
// Valid/ready stream with sop/eop framing, byte-modulo, error and control sideband.
interface if_axi_stream #(
    parameter int unsigned DAT_BITS = 64,
    parameter int unsigned CTL_BITS = common_pkg::STREAM_CTL_BITS,
    parameter int unsigned MOD_BITS = common_pkg::STREAM_MOD_BITS
);

    logic                val;
    logic                rdy;
    logic [DAT_BITS-1:0] dat;
    logic                sop;
    logic                eop;
    logic                err;
    logic [MOD_BITS-1:0] mod;
    logic [CTL_BITS-1:0] ctl;

    modport master (output val, dat, sop, eop, err, mod, ctl, input rdy);
    modport slave  (input val, dat, sop, eop, err, mod, ctl, output rdy);

endinterface

// File: rtl/multiexp_feeder_ram.sv
// Simple dual-port point/scalar buffer: one write port, one registered read port.
module multiexp_feeder_ram #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_dat,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_dat;
        if (rd_en) rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/multiexp_feeder.sv
// Buffers n {point, scalar} pairs, then replays them ITERS times to the multiexp core.
// MULTIEXP_FEEDER_PASS_CTL_EN puts the pass index on ctl[7:0]; otherwise ctl is zero.
module multiexp_feeder
    import multiexp_feeder_pkg::*;
#(
    parameter int unsigned NUM_IN_MAX = 8,
    parameter int unsigned ITERS      = $bits(bn128_pkg::fe_t),
    parameter int unsigned DAT_BITS   = $bits(bn128_pkg::fe_t) + $bits(bn128_pkg::jb_point_t)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [63:0]  i_num_in,
    if_axi_stream.slave  i_pnt_scl_if,
    if_axi_stream.master o_pnt_scl_if,
    output logic         o_busy,
    output logic         o_err
);

    localparam int unsigned NW = $clog2(NUM_IN_MAX + 1);
    localparam int unsigned AW = (NUM_IN_MAX > 1) ? $clog2(NUM_IN_MAX) : 1;
    localparam int unsigned PW = $clog2(ITERS + 1);

    state_e              state_q, state_d;
    logic [NW-1:0]       n_q, n_d, wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [PW-1:0]       pass_q, pass_d;
    logic                err_q, err_d, in_en_q;
    logic                pend_q, pend_d;
    logic [TAG_BITS-1:0] pend_tag_q, pend_tag_d;
    logic [1:0]          cnt_q;
    logic                wptr_q, rptr_q;
    logic [DAT_BITS-1:0] skid_dat_q [2];
    logic [TAG_BITS-1:0] skid_tag_q [2];

    logic                in_rdy, in_acc, num_over, wr_en, rd_en, issue;
    logic                out_val, out_pop, skid_push, skid_pop;
    logic [NW-1:0]       n_clamp;
    logic [AW-1:0]       wr_addr, rd_addr;
    logic [DAT_BITS-1:0] rd_dat;
    logic [TAG_BITS-1:0] head_tag;
    logic [2:0]          occ_now, occ_after;

    assign num_over = i_num_in > 64'(NUM_IN_MAX);
    assign n_clamp  = num_over ? NW'(NUM_IN_MAX) : NW'(i_num_in);
    assign in_rdy   = in_en_q && (state_q == StIdle || state_q == StLoad);
    assign in_acc   = in_rdy && i_pnt_scl_if.val;

    // Output side: skid entries first, else the RAM read register directly (bypass).
    assign out_val   = (cnt_q != 2'd0) || pend_q;
    assign out_pop   = out_val && o_pnt_scl_if.rdy;
    assign skid_pop  = out_pop && (cnt_q != 2'd0);
    assign skid_push = pend_q && !(out_pop && cnt_q == 2'd0);
    assign occ_now   = 3'(cnt_q) + 3'(pend_q);
    assign occ_after = occ_now - 3'(out_pop);
    // A read may only launch if its data is guaranteed a skid slot next cycle.
    assign issue     = (state_q == StReplay) && (pass_q != PW'(ITERS)) && (occ_after <= 3'd1);
    assign rd_addr   = AW'(rd_idx_q);

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        pass_d     = pass_q;
        err_d      = err_q;
        pend_d     = 1'b0;
        pend_tag_d = pend_tag_q;
        wr_en      = 1'b0;
        wr_addr    = AW'(wr_idx_q);
        rd_en      = 1'b0;
        unique case (state_q)
            StIdle: begin
                wr_addr = '0;
                if (in_acc && i_num_in != 64'd0) begin
                    wr_en    = 1'b1;
                    n_d      = n_clamp;
                    err_d    = err_q | num_over;
                    wr_idx_d = NW'(1);
                    rd_idx_d = '0;
                    pass_d   = '0;
                    state_d  = (n_clamp == NW'(1)) ? StReplay : StLoad;
                end
            end
            StLoad: begin
                if (in_acc) begin
                    wr_en    = 1'b1;
                    wr_idx_d = wr_idx_q + NW'(1);
                    if (wr_idx_q == n_q - NW'(1)) state_d = StReplay;
                end
            end
            StReplay: begin
                if (issue) begin
                    rd_en      = 1'b1;
                    pend_d     = 1'b1;
                    pend_tag_d = TAG_BITS'(pass_q);
                    if (rd_idx_q == n_q - NW'(1)) begin
                        rd_idx_d = '0;
                        pass_d   = pass_q + PW'(1);
                    end else begin
                        rd_idx_d = rd_idx_q + NW'(1);
                    end
                end
                if (pass_q == PW'(ITERS) && out_pop && occ_now == 3'd1) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StIdle;
            n_q        <= '0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            pass_q     <= '0;
            err_q      <= 1'b0;
            in_en_q    <= 1'b0;
            pend_q     <= 1'b0;
            pend_tag_q <= '0;
            cnt_q      <= '0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            in_en_q    <= 1'b1;
            pend_q     <= pend_d;
            pend_tag_q <= pend_tag_d;
            cnt_q      <= cnt_q + 2'(skid_push) - 2'(skid_pop);
            wptr_q     <= wptr_q ^ skid_push;
            rptr_q     <= rptr_q ^ skid_pop;
        end
    end

    always_ff @(posedge i_clk) begin
        if (skid_push) begin
            skid_dat_q[wptr_q] <= rd_dat;
            skid_tag_q[wptr_q] <= pend_tag_q;
        end
    end

    multiexp_feeder_ram #(
        .DEPTH    (NUM_IN_MAX),
        .WIDTH    (DAT_BITS),
        .ADDR_BITS(AW)
    ) u_ram (
        .clk    (i_clk),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_dat (i_pnt_scl_if.dat),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_dat (rd_dat)
    );

    assign head_tag = (cnt_q != 2'd0) ? skid_tag_q[rptr_q] : pend_tag_q;

    assign i_pnt_scl_if.rdy = in_rdy;
    assign o_pnt_scl_if.val = out_val;
    assign o_pnt_scl_if.dat = (cnt_q != 2'd0) ? skid_dat_q[rptr_q] : rd_dat;
    assign o_pnt_scl_if.sop = 1'b1;
    assign o_pnt_scl_if.eop = 1'b1;
    assign o_pnt_scl_if.err = 1'b0;
    assign o_pnt_scl_if.mod = '0;
`ifdef MULTIEXP_FEEDER_PASS_CTL_EN
    assign o_pnt_scl_if.ctl = common_pkg::STREAM_CTL_BITS'(head_tag);
`else
    logic unused_tag;
    assign unused_tag       = ^head_tag;
    assign o_pnt_scl_if.ctl = '0;
`endif

    logic unused_in;
    assign unused_in = ^{i_pnt_scl_if.sop, i_pnt_scl_if.eop, i_pnt_scl_if.err,
                         i_pnt_scl_if.mod, i_pnt_scl_if.ctl};

    assign o_busy = (state_q != StIdle);
    assign o_err  = err_q;

endmodule

// File: tb/tb_multiexp_feeder.sv
// Scoreboard bench for multiexp_feeder: expected replay beats are queued at load time
// and a negedge monitor pops and compares every transferred output beat.
module tb_multiexp_feeder;

    localparam int unsigned DW    = bn128_pkg::DAT_BITS;
    localparam int unsigned NMAX  = 8;
    localparam int unsigned NITER = 4;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic [7:0]    ctl;
    } exp_t;

    logic        clk, rst;
    logic [63:0] num_in;
    logic        busy, err;
    int          checks, errors, cyc;
    exp_t        sb_q[$];
    bit          rand_rdy;
    int          job_cnt, job_first, job_last;
    bit          busy_chk, hold_vld;
    logic [DW-1:0] hold_dat;

    if_axi_stream #(.DAT_BITS(DW)) in_if ();
    if_axi_stream #(.DAT_BITS(DW)) out_if ();

    multiexp_feeder #(
        .NUM_IN_MAX(NMAX),
        .ITERS     (NITER),
        .DAT_BITS  (DW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_num_in    (num_in),
        .i_pnt_scl_if(in_if),
        .o_pnt_scl_if(out_if),
        .o_busy      (busy),
        .o_err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int k);
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = 32'hC0DE_0000 ^ (32'(k) << 8) ^ 32'(i);
        return w;
    endfunction

    task automatic push_job(input int k0, input int n);
        exp_t e;
        for (int p = 0; p < NITER; p++) begin
            for (int i = 0; i < n; i++) begin
                e.dat = pat(k0 + i);
`ifdef MULTIEXP_FEEDER_PASS_CTL_EN
                e.ctl = 8'(p);
`else
                e.ctl = 8'h00;
`endif
                sb_q.push_back(e);
            end
        end
        job_cnt   = 0;
        job_first = -1;
    endtask

    // Offers each beat for a bounded number of cycles; unaccepted beats are withdrawn.
    task automatic load_job(input logic [63:0] num, input int k0, input int beats,
                            output int acc);
        acc = 0;
        for (int j = 0; j < beats; j++) begin
            int w;
            bit done;
            w = 0;
            done = 1'b0;
            in_if.val = 1'b1;
            in_if.dat = pat(k0 + j);
            num_in    = num;
            while (!done && w < 4) begin
                @(negedge clk);
                if (in_if.rdy) begin
                    done = 1'b1;
                    acc++;
                end
                @(posedge clk);
                #1;
                w++;
            end
            in_if.val = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while ((sb_q.size() != 0 || busy) && w < 400) begin
            @(posedge clk);
            w++;
        end
        check(name, 64'(w < 400), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_if.rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard pops, hold-under-backpressure, busy drop after the final beat.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy_chk) begin
                check("busy_after_last", 64'(busy), 64'd0);
                busy_chk = 1'b0;
            end
            if (hold_vld && !rst) begin
                check("hold_val", 64'(out_if.val), 64'd1);
                check("hold_dat", 64'(out_if.dat == hold_dat), 64'd1);
            end
            hold_vld = out_if.val && !out_if.rdy && !rst;
            hold_dat = out_if.dat;
            if (out_if.val && out_if.rdy && !rst) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_beat", 64'(out_if.dat[31:0]), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    checks++;
                    if (out_if.dat !== e.dat) begin
                        errors++;
                        $display("FAIL beat_dat act=%0h exp=%0h", out_if.dat[63:0], e.dat[63:0]);
                    end
                    check("beat_side", 64'({out_if.sop, out_if.eop, out_if.err, out_if.mod,
                                            out_if.ctl}),
                          64'({1'b1, 1'b1, 1'b0, 8'h00, e.ctl}));
                    if (job_first < 0) job_first = cyc;
                    job_last = cyc;
                    job_cnt++;
                    if (sb_q.size() == 0) busy_chk = 1'b1;
                end
            end
        end
    end

    initial begin
        int acc, w;
        bit seen;
        checks = 0;
        errors = 0;
        cyc = 0;
        rand_rdy = 1'b0;
        busy_chk = 1'b0;
        hold_vld = 1'b0;
        job_cnt = 0;
        job_first = -1;
        num_in = '0;
        in_if.val = 1'b0;
        in_if.dat = '0;
        in_if.sop = 1'b1;
        in_if.eop = 1'b1;
        in_if.err = 1'b0;
        in_if.mod = '0;
        in_if.ctl = '0;
        out_if.rdy = 1'b1;
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_out_val", 64'(out_if.val), 64'd0);
        check("rst_in_rdy", 64'(in_if.rdy), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_rdy_after_rst", 64'(in_if.rdy), 64'd1);

        // Full 8-pair job, output always ready.
        push_job(0, 8);
        load_job(64'd8, 0, 8, acc);
        check("load_a_acc", 64'(acc), 64'd8);
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (out_if.val) seen = 1'b1;
        end
        check("first_val_latency", 64'(seen), 64'd1);
        drain("drain_a");
        check("a_beats", 64'(job_cnt), 64'd32);
        check("a_no_bubbles", 64'(job_last - job_first), 64'd31);

        // Same job under random backpressure.
        rand_rdy = 1'b1;
        push_job(0, 8);
        load_job(64'd8, 0, 8, acc);
        drain("drain_b");
        check("b_beats", 64'(job_cnt), 64'd32);
        rand_rdy = 1'b0;

        // Zero-count beat is discarded.
        load_job(64'd0, 8'h30, 1, acc);
        @(negedge clk);
        check("zero_busy", 64'(busy), 64'd0);
        repeat (4) @(posedge clk);
        #1;

        // Single pair.
        push_job(8'h40, 1);
        load_job(64'd1, 8'h40, 1, acc);
        drain("drain_c");
        check("c_beats", 64'(job_cnt), 64'd4);
        check("c_err", 64'(err), 64'd0);

        // Oversized job: clamp, sticky error, extra beats dropped.
        push_job(8'h80, 8);
        load_job(64'd12, 8'h80, 12, acc);
        check("d_acc_clamped", 64'(acc), 64'd8);
        check("d_err", 64'(err), 64'd1);
        drain("drain_d");
        check("d_beats", 64'(job_cnt), 64'd32);
        check("d_err_sticky", 64'(err), 64'd1);

        // Reset on the 13th replay beat, then a fresh 2-pair job.
        push_job(8'hA0, 8);
        load_job(64'd8, 8'hA0, 8, acc);
        w = 0;
        while (job_cnt < 12 && w < 100) begin
            @(posedge clk);
            w++;
        end
        check("e_reach_beat13", 64'(job_cnt), 64'd12);
        check("e_val_before_rst", 64'(out_if.val), 64'd1);
        #2 rst = 1'b1;
        sb_q.delete();
        #1;
        check("e_rst_val", 64'(out_if.val), 64'd0);
        check("e_rst_busy", 64'(busy), 64'd0);
        check("e_rst_err", 64'(err), 64'd0);
        check("e_rst_in_rdy", 64'(in_if.rdy), 64'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check("e_in_rdy_after_rst", 64'(in_if.rdy), 64'd1);
        push_job(8'hC0, 2);
        load_job(64'd2, 8'hC0, 2, acc);
        drain("drain_e");
        check("e_beats", 64'(job_cnt), 64'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiexp_feeder.md
MULTIEXP_FEEDER -- requirements
Module: multiexp_feeder

Interface
REQ-001 SHALL have parameter NUM_IN_MAX, default 8, meaning depth of the point/scalar buffer.
REQ-002 SHALL have parameter ITERS, default $bits(fe_t), meaning replay passes (one per scalar bit).
REQ-003 SHALL have parameter DAT_BITS, default $bits(fe_t)+$bits(jb_point_t), meaning width of one packed {point, scalar} word.
REQ-004 SHALL have port i_clk, input, 1, meaning the single clock; every flop is in this domain.
REQ-005 SHALL have port i_rst, input, 1, meaning reset, asynchronous and active-high.
REQ-006 SHALL have port i_num_in, input, 64, meaning pair count, sampled on the first accepted load beat.
REQ-007 SHALL have port i_pnt_scl_if, if_axi_stream slave, DAT_BITS, meaning load stream; one beat per pair.
REQ-008 SHALL have port o_pnt_scl_if, if_axi_stream master, DAT_BITS, meaning replay stream to multiexp_top.
REQ-009 SHALL have port o_busy, output, 1, meaning high in any state except IDLE.
REQ-010 SHALL have port o_err, output, 1, meaning sticky flag: i_num_in exceeded NUM_IN_MAX.

Function
REQ-011 SHALL implement FSM IDLE -> LOAD -> REPLAY -> IDLE.
REQ-012 IDLE: i_pnt_scl_if.rdy=1; first accepted beat latches n=min(i_num_in,NUM_IN_MAX), writes mem[0], goes to LOAD (or REPLAY if n==1).
REQ-013 LOAD: i_pnt_scl_if.rdy=1; each accepted beat writes mem[wr_idx] and increments wr_idx; on nth beat go to REPLAY.
REQ-014 LOAD/REPLAY: beats beyond n in the current job SHALL be dropped (rdy=0 in REPLAY; no write past n).
REQ-015 i_num_in==0 on the first beat: beat is discarded, FSM stays in IDLE, no output.
REQ-016 i_num_in>NUM_IN_MAX: clamp to NUM_IN_MAX and set o_err until reset.
REQ-017 REPLAY: emit mem[0..n-1] in order, ITERS times; n*ITERS beats total; every beat has sop=eop=1, mod=0, err=0.
REQ-018 Output handshake: once o_pnt_scl_if.val=1, dat/ctl SHALL hold until rdy=1; val never deasserts without a transfer.
REQ-019 Throughput: one beat per cycle while rdy is held high, including across pass boundaries.
REQ-020 Latency: first output val no later than 2 cycles after the last load beat is accepted.
REQ-021 After the final beat of pass ITERS-1 is accepted, return to IDLE the next cycle; o_busy low that cycle.
REQ-022 Read index wraps n-1 -> 0 and increments pass counter; pass counter width $clog2(ITERS+1).

Reset
REQ-023 Asserting i_rst SHALL asynchronously force IDLE, i_pnt_scl_if.rdy=0, o_pnt_scl_if.val=0, o_busy=0, o_err=0, all counters 0.
REQ-024 Reset mid-REPLAY SHALL abort the job; val drops immediately; buffer contents are don't-care.
REQ-025 i_pnt_scl_if.rdy SHALL rise the first cycle after i_rst deasserts.

Configuration
REQ-026 Macro MULTIEXP_FEEDER_PASS_CTL_EN defined: o_pnt_scl_if.ctl[7:0] = pass index mod 256 of each beat.
REQ-027 Macro MULTIEXP_FEEDER_PASS_CTL_EN undefined: ctl=0; pass counter logic otherwise unchanged.

Structure
REQ-028 Packed {jb_point_t, fe_t} word typedef and DAT_BITS constant SHALL live in bn128_pkg; generic widths in common_pkg.
REQ-029 Buffer SHALL be a separate sub-module multiexp_feeder_ram: simple dual-port, 1-cycle read latency, NUM_IN_MAX x DAT_BITS.
REQ-030 A 2-entry output skid register SHALL hide RAM read latency under rdy backpressure.

Verification
REQ-031 Load 8 random pairs, num_in=8, ITERS=4, rdy=1 -> 32 beats, order p0..p7 repeated 4x, no bubbles after first beat.
REQ-032 Same stimulus with rdy toggled random 50% -> identical 32-beat sequence, dat stable while val&!rdy.
REQ-033 num_in=1, pair A -> 4 beats of A; busy falls 1 cycle after last transfer.
REQ-034 num_in=12, NUM_IN_MAX=8 -> o_err=1, first 8 pairs replayed, beats 9-12 dropped.
REQ-035 Assert i_rst at beat 13 of replay -> val=0 same cycle, new 2-pair job afterwards replays correctly.
REQ-036 Chain with multiexp_top, NUM_CORES=8 -> result equals multiexp_batch affine reference.
